// File: rtl/tenet_mac_scheduler_if.sv
// Requester, MAC and response signal bundle of the ternary MAC scheduler.
// master is the scheduler side; slave is requesters, MAC and consumer.
interface tenet_mac_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int VEC_LEN   = 9,
    parameter int ACC_WIDTH = 16
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*VEC_LEN*8-1:0] req_act;
    logic [NUM_REQ*VEC_LEN*2-1:0] req_wgt;

    logic                         mac_start;
    logic [VEC_LEN*8-1:0]         mac_activation;
    logic [VEC_LEN*2-1:0]         mac_weight;
    logic                         mac_done;
    logic signed [ACC_WIDTH-1:0]  mac_out;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic signed [ACC_WIDTH-1:0]  rsp_data;
    logic [IDW-1:0]               rsp_id;
    logic                         rsp_err;

    modport master (
        input  req_valid, req_act, req_wgt,
        input  mac_done, mac_out, rsp_ready,
        output req_ready, mac_start,
        output mac_activation, mac_weight,
        output rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        output req_valid, req_act, req_wgt,
        output mac_done, mac_out, rsp_ready,
        input  req_ready, mac_start,
        input  mac_activation, mac_weight,
        input  rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/tenet_mac_scheduler.sv
// Round-robin scheduler sharing one ternary MAC between NUM_REQ requesters,
// with all-zero-weight bypass, fault-trit rejection and a MAC watchdog.
module tenet_mac_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int VEC_LEN   = 9,
    parameter int ACC_WIDTH = 16,
    parameter int TIMEOUT   = 63
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tenet_mac_scheduler_if.master bus,
    output logic                 busy,
    output logic [15:0]          job_count
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int AW  = VEC_LEN * 8;
    localparam int WW  = VEC_LEN * 2;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef logic [IDW:0] cand_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                      state_q, state_d;
    logic [IDW-1:0]              ptr_q, ptr_d;
    logic [IDW-1:0]              id_q, id_d;
    logic [AW-1:0]               act_q, act_d;
    logic [WW-1:0]               wgt_q, wgt_d;
    logic [WDW-1:0]              wd_q, wd_d;
    logic signed [ACC_WIDTH-1:0] data_q, data_d;
    logic                        err_q, err_d;
    logic [15:0]                 cnt_q, cnt_d;

    logic                        gnt_vld;
    logic [IDW-1:0]              gnt_idx;
    cand_t                       cand;
    logic                        has_fault;
    logic                        all_zero;

    // Scan downward so the smallest offset from the pointer wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = cand_t'(ptr_q) + cand_t'(k);
            if (cand >= cand_t'(NUM_REQ))
                cand = cand - cand_t'(NUM_REQ);
            if (bus.req_valid[cand[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        has_fault = 1'b0;
        all_zero  = 1'b1;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (wgt_q[2*i +: 2] == 2'b11)
                has_fault = 1'b1;
            if (wgt_q[2*i +: 2] != 2'b00)
                all_zero = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        act_d         = act_q;
        wgt_d         = wgt_q;
        wd_d          = wd_q;
        data_d        = data_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        bus.req_ready = '0;
        bus.mac_start = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    bus.req_ready[gnt_idx] = 1'b1;
                    act_d   = bus.req_act[int'(gnt_idx)*AW +: AW];
                    wgt_d   = bus.req_wgt[int'(gnt_idx)*WW +: WW];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IDW'(NUM_REQ - 1)) ?
                              '0 : gnt_idx + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                unique case (1'b1)
                    has_fault: begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end
                    all_zero: begin
                        err_d   = 1'b0;
                        data_d  = '0;
                        state_d = S_RESP;
                    end
                    default: state_d = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                bus.mac_start = 1'b1;
                wd_d          = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final watchdog cycle still wins.
                if (bus.mac_done) begin
                    data_d  = bus.mac_out;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            act_q   <= '0;
            wgt_q   <= '0;
            wd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            act_q   <= act_d;
            wgt_q   <= wgt_d;
            wd_q    <= wd_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mac_activation = act_q;
    assign bus.mac_weight     = wgt_q;
    assign bus.rsp_data       = data_q;
    assign bus.rsp_id         = id_q;
    assign bus.rsp_err        = err_q;
    assign busy               = (state_q != S_IDLE);
    assign job_count          = cnt_q;
endmodule

// File: tb/tb_tenet_mac_scheduler.sv
// Directed self-checking bench for tenet_mac_scheduler with a
// behavioural ternary MAC driven from the falling clock edge.
module tb_tenet_mac_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int VEC_LEN   = 9;
    localparam int ACC_WIDTH = 16;
    localparam int TIMEOUT   = 63;
    localparam int AW        = VEC_LEN * 8;
    localparam int WW        = VEC_LEN * 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] job_count;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int mac_delay = VEC_LEN + 2;
    bit mac_hang = 1'b0;

    logic [AW-1:0] act5, act3;
    logic [WW-1:0] w_one, w_fault, w_neg;
    int lat, s0;

    tenet_mac_scheduler_if #(
        .NUM_REQ(NUM_REQ), .VEC_LEN(VEC_LEN), .ACC_WIDTH(ACC_WIDTH)
    ) bus ();

    tenet_mac_scheduler #(
        .NUM_REQ(NUM_REQ), .VEC_LEN(VEC_LEN),
        .ACC_WIDTH(ACC_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .job_count(job_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ACC_WIDTH-1:0] dot(input logic [AW-1:0] a,
                                                 input logic [WW-1:0] w);
        int s = 0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (w[2*i +: 2] == 2'b01)
                s += int'(a[8*i +: 8]);
            else if (w[2*i +: 2] == 2'b10)
                s -= int'(a[8*i +: 8]);
        end
        return ACC_WIDTH'(s);
    endfunction

    // MAC model: done is raised mac_delay cycles after the start cycle.
    initial begin
        logic [ACC_WIDTH-1:0] res;
        bus.mac_done = 1'b0;
        bus.mac_out  = '0;
        forever begin
            @(negedge clk);
            if (bus.mac_start === 1'b1) begin
                start_cnt++;
                if (!mac_hang) begin
                    res = dot(bus.mac_activation, bus.mac_weight);
                    repeat (mac_delay) @(negedge clk);
                    bus.mac_done = 1'b1;
                    bus.mac_out  = res;
                    @(negedge clk);
                    bus.mac_done = 1'b0;
                    bus.mac_out  = '0;
                end
            end
        end
    end

    task automatic issue(input int idx, input logic [AW-1:0] a,
                         input logic [WW-1:0] w);
        bus.req_act[idx*AW +: AW] = a;
        bus.req_wgt[idx*WW +: WW] = w;
        bus.req_valid = '0;
        bus.req_valid[idx] = 1'b1;
    endtask

    // Counts cycles from the grant cycle to the first rsp_valid cycle.
    task automatic wait_rsp(input bit drop, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop && n == 1)
                bus.req_valid = '0;
        end while (bus.rsp_valid !== 1'b1 && n < 200);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: end of sequence not reached");
        $fatal(1);
    end

    initial begin
        act5    = {VEC_LEN{8'd5}};
        act3    = {VEC_LEN{8'd3}};
        w_one   = 18'b00_00_10_00_00_00_01_01_01;
        w_fault = 18'b00_00_00_00_11_00_00_00_01;
        w_neg   = 18'b10_10_10_10_10_10_10_10_10;
        bus.req_valid = '0;
        bus.req_act   = '0;
        bus.req_wgt   = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mac_start", bus.mac_start, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", {bus.rsp_data}, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_job_count", job_count, 0);
        chk("rst_mac_act", bus.mac_activation, 0);
        chk("rst_mac_wgt", bus.mac_weight, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single job, result 5+5+5-5
        issue(0, act5, w_one);
        #1 chk("t1_grant", bus.req_ready, 4'b0001);
        s0 = start_cnt;
        wait_rsp(1'b1, lat);
        chk("t1_latency", lat, 14);
        chk("t1_data", {bus.rsp_data}, 16'd10);
        chk("t1_id", bus.rsp_id, 0);
        chk("t1_err", bus.rsp_err, 0);
        chk("t1_busy", busy, 1);
        chk("t1_mac_act", bus.mac_activation, act5);
        chk("t1_mac_wgt", bus.mac_weight, w_one);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_count_pre", job_count, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_count", job_count, 1);
        chk("t1_rsp_clear", bus.rsp_valid, 0);
        chk("t1_idle", busy, 0);

        rst_n = 1'b0;
        #1 chk("rst2_count", job_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fairness: everybody requests continuously
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_act[i*AW +: AW] = {VEC_LEN{8'(i + 1)}};
            bus.req_wgt[i*WW +: WW] = 18'b01;
        end
        bus.req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            wait_rsp(1'b0, lat);
            chk("rr_latency", lat, (j == 0) ? 14 : 15);
            chk("rr_id", bus.rsp_id, j % 4);
            chk("rr_data", {bus.rsp_data}, 16'(j % 4 + 1));
        end
        bus.req_valid = '0;
        @(negedge clk);
        chk("rr_count", job_count, 8);

        // bypass: all-zero weights
        issue(2, act5, '0);
        #1 chk("byp_grant", bus.req_ready, 4'b0100);
        s0 = start_cnt;
        wait_rsp(1'b1, lat);
        chk("byp_latency", lat, 2);
        chk("byp_data", {bus.rsp_data}, 0);
        chk("byp_err", bus.rsp_err, 0);
        chk("byp_id", bus.rsp_id, 2);
        chk("byp_starts", start_cnt - s0, 0);
        @(negedge clk);

        // fault trit
        issue(1, act5, w_fault);
        #1 chk("flt_grant", bus.req_ready, 4'b0010);
        s0 = start_cnt;
        wait_rsp(1'b1, lat);
        chk("flt_latency", lat, 2);
        chk("flt_err", bus.rsp_err, 1);
        chk("flt_data", {bus.rsp_data}, 0);
        chk("flt_id", bus.rsp_id, 1);
        chk("flt_starts", start_cnt - s0, 0);
        @(negedge clk);

        // hung MAC: timeout after 63 WAIT cycles
        mac_hang = 1'b1;
        issue(0, act5, w_one);
        s0 = start_cnt;
        wait_rsp(1'b1, lat);
        chk("to_latency", lat, 66);
        chk("to_err", bus.rsp_err, 1);
        chk("to_data", {bus.rsp_data}, 0);
        chk("to_id", bus.rsp_id, 0);
        chk("to_starts", start_cnt - s0, 1);
        @(negedge clk);
        mac_hang = 1'b0;

        // done on the last WAIT cycle beats the watchdog
        mac_delay = 63;
        issue(3, act3, w_neg);
        wait_rsp(1'b1, lat);
        chk("late_latency", lat, 66);
        chk("late_err", bus.rsp_err, 0);
        chk("late_data", {bus.rsp_data}, 16'hFFE5);
        chk("late_id", bus.rsp_id, 3);
        @(negedge clk);
        mac_delay = VEC_LEN + 2;

        // backpressure
        bus.rsp_ready = 1'b0;
        issue(1, act5, w_one);
        #1 chk("bp_grant", bus.req_ready, 4'b0010);
        wait_rsp(1'b1, lat);
        chk("bp_latency", lat, 14);
        bus.req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", {bus.rsp_data}, 16'd10);
            chk("bp_id", bus.rsp_id, 1);
            chk("bp_no_grant", bus.req_ready, 0);
        end
        chk("bp_count_pre", job_count, 12);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_count", job_count, 13);
        chk("bp_idle", busy, 0);

        // reset while waiting on the MAC
        mac_hang = 1'b1;
        issue(2, act5, w_one);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", job_count, 0);
        chk("mid_rst_valid", bus.rsp_valid, 0);
        chk("mid_rst_start", bus.mac_start, 0);
        chk("mid_rst_wgt", bus.mac_weight, 0);
        chk("mid_rst_act", bus.mac_activation, 0);
        chk("mid_rst_id", bus.rsp_id, 0);
        chk("mid_rst_data", {bus.rsp_data}, 0);
        chk("mid_rst_err", bus.rsp_err, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mac_hang = 1'b0;
        bus.req_valid = 4'hF;
        #1 chk("post_rst_grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/tenet_mac_scheduler.md
Name: tenet_mac_scheduler

Overview:
- Round-robin scheduler that shares one tenet_dataflow ternary MAC unit between NUM_REQ requesters.
- Per job:
  - Arbitrates among valid requests.
  - Latches the job's activation and weight vectors.
  - Sequences the MAC start/done protocol.
  - Returns the result with a valid/ready handshake.
- All-zero weight vectors bypass the MAC. A watchdog guards against a hung MAC.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VEC_LEN, 9, trits per weight vector; activations 8 bits each.
- ACC_WIDTH, 16, MAC result width.
- TIMEOUT, 63, max cycles in WAIT before declaring MAC hang.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot grant; job accepted when valid&ready.
- req_act  in  NUM_REQ*VEC_LEN*8  activation vectors; requester i at [i*VEC_LEN*8 +: VEC_LEN*8].
- req_wgt  in  NUM_REQ*VEC_LEN*2  weight vectors, 2b/trit: 01=+1, 00=0, 10=-1, 11=fault.
- mac_start  out  1  one-cycle start pulse to MAC.
- mac_activation  out  VEC_LEN*8  latched activation to MAC.
- mac_weight  out  VEC_LEN*2  latched weight to MAC.
- mac_done  in  1  MAC completion pulse.
- mac_out  in  ACC_WIDTH signed  MAC result, valid with mac_done.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  ACC_WIDTH signed  result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester whose job this is.
- rsp_err  out  1  job had a fault trit or timed out.
- busy  out  1  state != IDLE.
- job_count  out  16  completed responses, wraps at 0xFFFF.

Behaviour:
- Reset values: every output 0; round-robin pointer 0; state IDLE; latched vectors 0.
- IDLE:
  - If any req_valid, grant exactly one requester: the first valid at or after the pointer, modulo NUM_REQ.
  - req_ready is combinational: high only in IDLE, only for the granted index.
  - On handshake, latch act/wgt/id, set pointer = grant+1 (wrap), and go to CHECK.
  - With no valid request, stay in IDLE; pointer unchanged.
- CHECK (1 cycle):
  - Any weight trit == 11 → rsp_err=1, rsp_data=0, go to RESP.
  - Else all trits == 00 → rsp_err=0, rsp_data=0, go to RESP (MAC bypass).
  - Else go to ISSUE.
- ISSUE: assert mac_start for exactly 1 cycle, clear the watchdog, go to WAIT. mac_activation/mac_weight hold latched values from CHECK through WAIT.
- WAIT:
  - mac_done=1 → rsp_data=mac_out, rsp_err=0, go to RESP.
  - Watchdog increments each cycle. On reaching TIMEOUT without mac_done → rsp_err=1, rsp_data=0, go to RESP.
  - mac_done on the same cycle the watchdog reaches TIMEOUT: done wins.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id/rsp_err stable until rsp_valid&rsp_ready.
  - On handshake: job_count+1, rsp_valid←0, go to IDLE. The next grant is no earlier than the following cycle, so there is one idle bubble.
- mac_done outside WAIT is ignored.
- req_valid changes outside IDLE have no effect; no grant outside IDLE.
- Latency, nonzero job with an ideal MAC (VEC_LEN+2 cycles start→done): grant → rsp_valid = VEC_LEN+5 cycles.
- Latency, bypass/fault job: grant → rsp_valid = 2 cycles.
- rst_n low mid-job: immediate return to reset values. In-flight job dropped, no response. Requester must re-request.
- Arithmetic: rsp_data passes mac_out unchanged (no resize). job_count wraps modulo 2^16.

Test Plan:
- Single job: req 0 act all 5, weights [+1,+1,+1,0,0,0,-1,0,0], model MAC → rsp_data=10, rsp_id=0, rsp_err=0, job_count=1.
- Fairness: all 4 req_valid held high for 8 jobs, rsp_ready=1 → grant order 0,1,2,3,0,1,2,3.
- Bypass: req 2 all weights 00 → rsp_valid 2 cycles after grant, rsp_data=0, mac_start never pulses.
- Fault: req 1 trit 4 = 11 → rsp_err=1, rsp_data=0, no mac_start.
- Timeout: MAC model never asserts mac_done → rsp_err=1 after exactly TIMEOUT=63 WAIT cycles. Also: mac_done on the 63rd WAIT cycle → rsp_err=0, rsp_data=mac_out.
- Backpressure and reset:
  - rsp_ready low 10 cycles → rsp_valid/data/id held, req_ready all 0.
  - Then rst_n pulsed low during WAIT → all outputs 0, job_count 0, next grant starts at requester 0.
